// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the Mini SRC datapath
module control_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        stop,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        PCout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        PCin,
   output logic        IncPC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zin,
   output logic        HIin,
   output logic        LOin,
   output logic        CONin,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  alu_op,
   output logic        run
);

   localparam logic [4:0] OP_ADD = 5'b00011;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   state_t     state, state_nx;
   logic [4:0] opcode;
   logic       c_alu, c_imm, c_ldi, c_ld, c_st, c_muldiv, c_negnot;
   logic       c_br, c_jr, c_mfhi, c_mflo, c_halt, c_none, last_step;
   logic       unused_ir_bits;

   assign opcode         = IR[31:27];
   assign unused_ir_bits = ^IR[26:0];

   // Instruction class decode and end-of-instruction detection
   always_comb begin
      c_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
      c_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
      c_ldi    = (opcode == 5'b00001);
      c_ld     = (opcode == 5'b00000);
      c_st     = (opcode == 5'b00010);
      c_muldiv = (opcode == 5'b10000) || (opcode == 5'b01111);
      c_negnot = (opcode == 5'b10001) || (opcode == 5'b10010);
      c_br     = (opcode == 5'b10011);
      c_jr     = (opcode == 5'b10100);
      c_mfhi   = (opcode == 5'b11000);
      c_mflo   = (opcode == 5'b11001);
      c_halt   = (opcode == 5'b11011);
      // nop and every unlisted opcode skip the execute phase entirely
      c_none   = !(c_alu || c_imm || c_ldi || c_ld || c_st || c_muldiv || c_negnot ||
                   c_br || c_jr || c_mfhi || c_mflo || c_halt);
      last_step = 1'b0;
      case (state)
         S_T2:    last_step = c_none;
         S_T3:    last_step = c_jr || c_mfhi || c_mflo;
         S_T4:    last_step = c_negnot;
         S_T5:    last_step = c_alu || c_imm || c_ldi;
         S_T6:    last_step = c_muldiv || c_br;
         S_T7:    last_step = c_ld || c_st;
         default: last_step = 1'b0;
      endcase
   end

   // State register; reset overrides any step, including mid-instruction
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_RESET;
      else          state <= state_nx;
   end

   // Next-state: advance one step per clock, stop only takes effect at the boundary
   always_comb begin
      state_nx = state;
      if (state == S_T2 && c_halt) begin
         state_nx = S_HALT;
      end else if (last_step) begin
         state_nx = stop ? S_HALT : S_T0;
      end else begin
         case (state)
            S_RESET: state_nx = S_T0;
            S_T0:    state_nx = S_T1;
            S_T1:    state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            S_T3:    state_nx = S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = S_T6;
            S_T6:    state_nx = S_T7;
            S_T7:    state_nx = S_T0;
            default: state_nx = S_HALT;
         endcase
      end
   end

   // Strobe decode from the registered step and the opcode class
   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
      HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
      PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0;
      Read = 1'b0; Write = 1'b0; alu_op = 5'b00000;
      run = (state != S_RESET) && (state != S_HALT);
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (c_alu || c_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            else if (c_ldi || c_ld || c_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            else if (c_muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            else if (c_negnot) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            else if (c_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            else if (c_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            else if (c_mfhi || c_mflo) begin
               HIout = c_mfhi; LOout = c_mflo; Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T4: begin
            if (c_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            else if (c_imm) begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            else if (c_ldi || c_ld || c_st) begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
            else if (c_muldiv) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            else if (c_negnot) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (c_br) begin PCout = 1'b1; Yin = 1'b1; end
         end
         S_T5: begin
            if (c_alu || c_imm || c_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (c_ld || c_st) begin Zlowout = 1'b1; MARin = 1'b1; end
            else if (c_muldiv) begin Zlowout = 1'b1; LOin = 1'b1; end
            else if (c_br) begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
         end
         S_T6: begin
            if (c_ld) begin Read = 1'b1; MDRin = 1'b1; end
            else if (c_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            else if (c_muldiv) begin Zhighout = 1'b1; HIin = 1'b1; end
            else if (c_br && CON_FF) begin Zlowout = 1'b1; PCin = 1'b1; end
         end
         S_T7: begin
            if (c_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (c_st) Write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed table-driven bench for control_sequencer
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, CON_FF, stop;
   logic [31:0] IR;
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
   logic PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, Read, Write, run;
   logic [4:0] alu_op;

   control_sequencer dut (
      .clk(clk), .reset_n(reset_n), .IR(IR), .CON_FF(CON_FF), .stop(stop),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .Cout(Cout),
      .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
      .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
      .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
   );

   always #5 clk = ~clk;

   // Observed output word, one bit per strobe, alu_op in [5:1], run in [0]
   localparam logic [30:0] RUN = 31'd1 << 0,  WRITE = 31'd1 << 6,  READ = 31'd1 << 7;
   localparam logic [30:0] CONIN = 31'd1 << 8, LOIN = 31'd1 << 9,  HIIN = 31'd1 << 10;
   localparam logic [30:0] ZIN = 31'd1 << 11,  YIN = 31'd1 << 12,  MDRIN = 31'd1 << 13;
   localparam logic [30:0] MARIN = 31'd1 << 14, IRIN = 31'd1 << 15, INCPC = 31'd1 << 16;
   localparam logic [30:0] PCIN = 31'd1 << 17, COUT = 31'd1 << 18, LOOUT = 31'd1 << 19;
   localparam logic [30:0] HIOUT = 31'd1 << 20, MDROUT = 31'd1 << 21, ZLOWOUT = 31'd1 << 22;
   localparam logic [30:0] ZHIGHOUT = 31'd1 << 23, PCOUT = 31'd1 << 24, BAOUT = 31'd1 << 25;
   localparam logic [30:0] ROUT = 31'd1 << 26, RIN = 31'd1 << 27, GRC = 31'd1 << 28;
   localparam logic [30:0] GRB = 31'd1 << 29, GRA = 31'd1 << 30;
   localparam logic [30:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
   localparam logic [30:0] F1 = RUN | ZLOWOUT | PCIN | READ | MDRIN;
   localparam logic [30:0] F2 = RUN | MDROUT | IRIN;

   localparam logic [31:0] I_ADD = 32'h18918000, I_LD = 32'h00800010, I_ST = 32'h10800010;
   localparam logic [31:0] I_BR = 32'h98000000, I_NOP = 32'hD0000000, I_JR = 32'hA0000000;
   localparam logic [31:0] I_MFHI = 32'hC0000000, I_NEG = 32'h88000000, I_MUL = 32'h80000000;
   localparam logic [31:0] I_ADDI = 32'h60000000, I_BAD = 32'hF8000000, I_HALT = 32'hD8000000;

   typedef struct {
      logic [31:0] ir;
      logic        con;
      logic [30:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [30:0] alu(input logic [4:0] op);
      return {25'd0, op, 1'b0};
   endfunction

   function automatic logic [30:0] observed();
      return {Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
              Cout, PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, Read, Write,
              alu_op, run};
   endfunction

   task automatic add_row(input logic [31:0] ir, input logic con, input logic [30:0] exp);
      vec_t v;
      v.ir = ir; v.con = con; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock step: inputs applied just after the edge, outputs sampled on the falling edge
   task automatic cyc(input string name, input logic [31:0] ir, input logic con,
                      input logic stp, input logic [30:0] exp);
      #1;
      IR = ir; CON_FF = con; stop = stp;
      @(negedge clk);
      check(name, observed(), exp);
      @(posedge clk);
   endtask

   task automatic do_reset();
      #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("reset_state", observed(), 31'd0);
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; IR = 32'd0; CON_FF = 1'b0; stop = 1'b0;

      add_row(I_ADD, 0, F0); add_row(I_ADD, 0, F1); add_row(I_ADD, 0, F2);
      add_row(I_ADD, 0, RUN | GRB | ROUT | YIN);
      add_row(I_ADD, 0, RUN | GRC | ROUT | ZIN | alu(5'b00011));
      add_row(I_ADD, 0, RUN | ZLOWOUT | GRA | RIN);
      add_row(I_LD, 0, F0); add_row(I_LD, 0, F1); add_row(I_LD, 0, F2);
      add_row(I_LD, 0, RUN | GRB | BAOUT | YIN);
      add_row(I_LD, 0, RUN | COUT | ZIN | alu(5'b00011));
      add_row(I_LD, 0, RUN | ZLOWOUT | MARIN);
      add_row(I_LD, 0, RUN | READ | MDRIN);
      add_row(I_LD, 0, RUN | MDROUT | GRA | RIN);
      add_row(I_ST, 0, F0); add_row(I_ST, 0, F1); add_row(I_ST, 0, F2);
      add_row(I_ST, 0, RUN | GRB | BAOUT | YIN);
      add_row(I_ST, 0, RUN | COUT | ZIN | alu(5'b00011));
      add_row(I_ST, 0, RUN | ZLOWOUT | MARIN);
      add_row(I_ST, 0, RUN | GRA | ROUT | MDRIN);
      add_row(I_ST, 0, RUN | WRITE);
      for (int c = 0; c < 2; c++) begin
         add_row(I_BR, c[0], F0); add_row(I_BR, c[0], F1); add_row(I_BR, c[0], F2);
         add_row(I_BR, c[0], RUN | GRA | ROUT | CONIN);
         add_row(I_BR, c[0], RUN | PCOUT | YIN);
         add_row(I_BR, c[0], RUN | COUT | ZIN | alu(5'b00011));
         add_row(I_BR, c[0], c[0] ? (RUN | ZLOWOUT | PCIN) : RUN);
      end
      add_row(I_NOP, 0, F0); add_row(I_NOP, 0, F1); add_row(I_NOP, 0, F2);
      add_row(I_JR, 0, F0); add_row(I_JR, 0, F1); add_row(I_JR, 0, F2);
      add_row(I_JR, 0, RUN | GRA | ROUT | PCIN);
      add_row(I_MFHI, 0, F0); add_row(I_MFHI, 0, F1); add_row(I_MFHI, 0, F2);
      add_row(I_MFHI, 0, RUN | HIOUT | GRA | RIN);
      add_row(I_NEG, 0, F0); add_row(I_NEG, 0, F1); add_row(I_NEG, 0, F2);
      add_row(I_NEG, 0, RUN | GRB | ROUT | ZIN | alu(5'b10001));
      add_row(I_NEG, 0, RUN | ZLOWOUT | GRA | RIN);
      add_row(I_MUL, 0, F0); add_row(I_MUL, 0, F1); add_row(I_MUL, 0, F2);
      add_row(I_MUL, 0, RUN | GRA | ROUT | YIN);
      add_row(I_MUL, 0, RUN | GRB | ROUT | ZIN | alu(5'b10000));
      add_row(I_MUL, 0, RUN | ZLOWOUT | LOIN);
      add_row(I_MUL, 0, RUN | ZHIGHOUT | HIIN);
      add_row(I_ADDI, 0, F0); add_row(I_ADDI, 0, F1); add_row(I_ADDI, 0, F2);
      add_row(I_ADDI, 0, RUN | GRB | ROUT | YIN);
      add_row(I_ADDI, 0, RUN | COUT | ZIN | alu(5'b01100));
      add_row(I_ADDI, 0, RUN | ZLOWOUT | GRA | RIN);
      add_row(I_BAD, 0, F0); add_row(I_BAD, 0, F1); add_row(I_BAD, 0, F2);
      add_row(I_NOP, 0, F0);

      do_reset();
      foreach (vecs[i]) cyc($sformatf("row%0d", i), vecs[i].ir, vecs[i].con, 1'b0, vecs[i].exp);

      // halt: HALT follows T2, holds all-zero, only reset restarts
      cyc("halt_t1", I_HALT, 0, 0, F1);
      cyc("halt_t2", I_HALT, 0, 0, F2);
      for (int i = 0; i < 20; i++) cyc($sformatf("halt_hold%0d", i), I_HALT, 0, 0, 31'd0);
      do_reset();
      cyc("restart_t0", I_LD, 0, 0, F0);

      // reset asserted during T6 of ld
      cyc("ld_t1", I_LD, 0, 0, F1);
      cyc("ld_t2", I_LD, 0, 0, F2);
      cyc("ld_t3", I_LD, 0, 0, RUN | GRB | BAOUT | YIN);
      cyc("ld_t4", I_LD, 0, 0, RUN | COUT | ZIN | alu(5'b00011));
      cyc("ld_t5", I_LD, 0, 0, RUN | ZLOWOUT | MARIN);
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("ld_t6_pre_reset", observed(), RUN | READ | MDRIN);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("ld_reset_mid", observed(), 31'd0);
      @(posedge clk);

      // stop raised in T4 of add and held: T5 completes, then HALT
      cyc("stop_t0", I_ADD, 0, 0, F0);
      cyc("stop_t1", I_ADD, 0, 0, F1);
      cyc("stop_t2", I_ADD, 0, 0, F2);
      cyc("stop_t3", I_ADD, 0, 0, RUN | GRB | ROUT | YIN);
      cyc("stop_t4", I_ADD, 0, 1, RUN | GRC | ROUT | ZIN | alu(5'b00011));
      cyc("stop_t5", I_ADD, 0, 1, RUN | ZLOWOUT | GRA | RIN);
      cyc("stop_halt", I_ADD, 0, 0, 31'd0);
      cyc("stop_halt2", I_ADD, 0, 0, 31'd0);

      // stop pulsed mid-instruction only: instruction ends normally at T0
      do_reset();
      cyc("pulse_t0", I_JR, 0, 0, F0);
      cyc("pulse_t1", I_JR, 0, 1, F1);
      cyc("pulse_t2", I_JR, 0, 0, F2);
      cyc("pulse_t3", I_JR, 0, 0, RUN | GRA | ROUT | PCIN);
      cyc("pulse_next_t0", I_JR, 0, 0, F0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit for the Mini SRC datapath. It steps each instruction through fetch (T0–T2) and a class-specific execute sequence (T3–T7). In each step it drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) into the select-and-encode logic, plus the bus-driver, register-load, memory and ALU controls. It sits between the IR and the datapath and is the only source of datapath control strobes.

## Interface
- OP_ADD, 5'b00011, ALU opcode forced during address and branch-target computation.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- IR  in  32  instruction register; opcode = IR[31:27]
- CON_FF  in  1  branch-condition flag from the datapath
- stop  in  1  request to halt at the next instruction boundary
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to select-and-encode logic
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout  out  1 each  bus drivers
- PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin  out  1 each  register loads
- Read, Write  out  1 each  memory strobes (fixed one-cycle memory)
- alu_op  out  5  ALU function select
- run  out  1  high while executing

## Operation
- State register: RESET, T0–T7, HALT. Outputs are decoded combinationally from the registered state and IR[31:27]. IR only changes at T2, so the opcode is stable from T3 onward.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- Execute by opcode; the step after the listed last step is T0 unless noted.
  - ALU reg (00011–01011: add, sub, and, or, ror, rol, shr, shra, shl):
    - T3: Grb, Rout, Yin
    - T4: Grc, Rout, Zin, alu_op=opcode
    - T5: Zlowout, Gra, Rin
  - ALU imm (01100–01110):
    - T3: Grb, Rout, Yin
    - T4: Cout, Zin, alu_op=opcode
    - T5: Zlowout, Gra, Rin
  - ldi (00001):
    - T3: Grb, BAout, Yin
    - T4: Cout, Zin, alu_op=OP_ADD
    - T5: Zlowout, Gra, Rin
  - ld (00000):
    - T3–T4 as ldi
    - T5: Zlowout, MARin
    - T6: Read, MDRin
    - T7: MDRout, Gra, Rin
  - st (00010):
    - T3–T5 as ld
    - T6: Gra, Rout, MDRin
    - T7: Write
  - mul/div (10000/01111):
    - T3: Gra, Rout, Yin
    - T4: Grb, Rout, Zin, alu_op=opcode
    - T5: Zlowout, LOin
    - T6: Zhighout, HIin
  - neg/not (10001/10010):
    - T3: Grb, Rout, Zin, alu_op=opcode
    - T4: Zlowout, Gra, Rin
  - br (10011):
    - T3: Gra, Rout, CONin
    - T4: PCout, Yin
    - T5: Cout, Zin, alu_op=OP_ADD
    - T6: Zlowout and PCin only if CON_FF=1; otherwise no strobes
  - jr (10100): T3: Gra, Rout, PCin
  - mfhi/mflo (11000/11001): T3: HIout or LOout, Gra, Rin
  - nop (11010) and all unlisted opcodes: T2 → T0 directly.
  - halt (11011): T2 → HALT.
- Outside ALU-compute steps alu_op = 5'b00000. Asserted Gra/Grb/Grc are mutually exclusive in every state.
- Instruction boundary: the last step of an instruction. If stop=1 at that clock edge, the next state is HALT instead of T0.

## Timing
- reset_n=0 at a rising edge puts the state in RESET regardless of current state, including mid-instruction. No partial strobe survives past that edge.
- In RESET all outputs are 0, including run. The first edge with reset_n=1 moves RESET → T0.
- run=1 in T0–T7; run=0 in RESET and HALT.
- HALT: all strobes 0. It is left only via reset.
- One state per clock; no wait states. Per-class latencies including fetch:
  - nop: 3 cycles
  - jr, mfhi, mflo: 4 cycles
  - neg, not: 5 cycles
  - ALU, ldi: 6 cycles
  - mul, div, br: 7 cycles
  - ld, st: 8 cycles
- br: CON_FF is sampled combinationally in T6; CONin was loaded in T3.
- stop arriving mid-instruction does not truncate it. Only its value at the boundary edge counts.

## Test plan
- Reset: hold reset_n=0 for 2 cycles, release. Every output is 0 with run=0 for exactly 1 cycle after release, then T0 asserts PCout, MARin, IncPC, Zin.
- add r1,r2,r3 (IR=0x18918000):
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, alu_op=00011
  - T5: Zlowout, Gra, Rin
  - The next cycle is T0.
- ld then st (opcodes 00000, 00010): Read pulses at T1 and T6 of ld, and MDRout/Gra/Rin at T7. Write pulses exactly once, at T7 of st. Each instruction takes 8 cycles.
- br with CON_FF=0 then CON_FF=1: PCin is absent in T6 in the first case and asserted with Zlowout in the second. Both take 7 cycles.
- halt (IR=0xD8000000): HALT follows T2 and run drops. A 20-cycle hold keeps all strobes 0. Pulsing reset_n restarts at T0.
- Reset mid-ld: assert reset_n=0 during T6. The next cycle is RESET with Read=0 and MDRin=0. Separately, stop=1 during T4 of add still completes T5, then enters HALT.
